dim_fade_ctrl: RTL and testbench

//  Frame-synchronous controller for the radial dim shader. Owns the shader's

---
 rtl/dim_fade_ctrl_if.sv | 10 +
 rtl/dim_fade_ctrl.sv | 129 ++++++++++++
 tb/tb_dim_fade_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/dim_fade_ctrl_if.sv
// Colour-change request channel between the game/menu requester and the fade controller.
interface dim_fade_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_color;
    logic [1:0]  req_mode;

    modport master (output req_valid, output req_color, output req_mode, input  req_ready);
    modport slave  (input  req_valid, input  req_color, input  req_mode, output req_ready);
endinterface

// File: rtl/dim_fade_ctrl.sv
// Frame-synchronous owner of the dim shader base colour and global fade level.
// Colour changes land on frame ticks as a cut, a crossfade, or a fade-in.
module dim_fade_ctrl #(
    parameter int unsigned STEP_FRAMES = 4,
    parameter int unsigned MAX_LEVEL   = 15,
    parameter logic [11:0] INIT_COLOR  = 12'hFFF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              frame_tick_i,
    dim_fade_ctrl_if.slave    req,
    output logic [11:0]       pri_color_o,
    output logic [3:0]        fade_level_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned    CW       = $clog2(STEP_FRAMES) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(STEP_FRAMES - 1);
    localparam logic [3:0]     LVL_MAX  = 4'(MAX_LEVEL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CUT_WAIT,
        S_ARM,
        S_FADE_OUT,
        S_FADE_IN
    } state_e;

    state_e         state_q, state_d;
    logic [11:0]    pri_q, pri_d;
    logic [11:0]    held_q, held_d;
    logic [3:0]     level_q, level_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;
    logic           step_hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            pri_q   <= INIT_COLOR;
            held_q  <= '0;
            level_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
            held_q  <= held_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // A fade step completes on the tick that finds the counter at its last value.
    assign step_hit = frame_tick_i && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        pri_d   = pri_q;
        held_d  = held_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req.req_valid) begin
                    held_d = req.req_color;
                    cnt_d  = '0;
                    unique case (req.req_mode)
                        2'b01:   state_d = S_FADE_OUT;
                        2'b10:   state_d = S_ARM;
                        default: state_d = S_CUT_WAIT;
                    endcase
                end
            end
            S_CUT_WAIT: begin
                if (frame_tick_i) begin
                    pri_d   = held_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ARM: begin
                if (frame_tick_i) begin
                    pri_d   = held_q;
                    level_d = LVL_MAX;
                    state_d = S_FADE_IN;
                end
            end
            S_FADE_OUT: begin
                if (step_hit) begin
                    cnt_d = '0;
                    if (level_q == LVL_MAX) begin
                        pri_d   = held_q;
                        state_d = S_FADE_IN;
                    end else begin
                        level_d = level_q + 4'd1;
                    end
                end else if (frame_tick_i) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FADE_IN: begin
                if (step_hit) begin
                    cnt_d = '0;
                    if (level_q == '0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        level_d = level_q - 4'd1;
                    end
                end else if (frame_tick_i) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req.req_ready = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign pri_color_o   = pri_q;
    assign fade_level_o  = level_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_dim_fade_ctrl.sv
// Scoreboard bench for dim_fade_ctrl: completion colours are queued at request
// time and checked when done pulses; per-tick levels come from fixed tables.
module tb_dim_fade_ctrl;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b1;
    logic        frame_tick = 1'b0;
    logic [11:0] pri_color;
    logic [3:0]  fade_level;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] exp_done_q[$];
    logic        prev_done = 1'b0;

    dim_fade_ctrl_if bus ();

    dim_fade_ctrl #(
        .STEP_FRAMES (2),
        .MAX_LEVEL   (3),
        .INIT_COLOR  (12'hFFF)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .frame_tick_i (frame_tick),
        .req          (bus),
        .pri_color_o  (pri_color),
        .fade_level_o (fade_level),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Completion scoreboard: every done pulse must match the oldest queued request.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_done_q.size() == 0)
                chk("done_unexpected", done, 1'b0);
            else
                chk("done_color", pri_color, exp_done_q.pop_front());
            chk("done_ready", bus.req_ready, 1'b1);
            chk("done_width", prev_done, 1'b0);
        end
        prev_done <= done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] c, input logic [1:0] m);
        bit ok;
        ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_color = c;
        bus.req_mode  = m;
        for (int i = 0; i < 200 && !ok; i++) begin
            ok = bus.req_ready;
            step();
        end
        bus.req_valid = 1'b0;
        if (!ok) chk("accept_timeout", ok, 1'b1);
    endtask

    task automatic tick_gap();
        repeat (19) step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic chk_idle_defaults(input string tag);
        chk({tag, "_pri"},   pri_color,     12'hFFF);
        chk({tag, "_level"}, fade_level,    4'd0);
        chk({tag, "_busy"},  busy,          1'b0);
        chk({tag, "_ready"}, bus.req_ready, 1'b1);
        chk({tag, "_done"},  done,          1'b0);
    endtask

    int unsigned xf_lvl[16] = '{0, 1, 1, 2, 2, 3, 3, 3, 3, 2, 2, 1, 1, 0, 0, 0};
    int unsigned fi_lvl[9]  = '{3, 3, 2, 2, 1, 1, 0, 0, 0};

    initial begin
        bus.req_valid = 1'b0;
        bus.req_color = '0;
        bus.req_mode  = '0;

        // Reset
        #1 rst_n = 1'b0;
        #1 chk_idle_defaults("rst0");
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Cut between ticks
        send(12'h0F0, 2'b00);
        chk("cut_pri_hold", pri_color, 12'hFFF);
        chk("cut_busy", busy, 1'b1);
        chk("cut_ready", bus.req_ready, 1'b0);
        exp_done_q.push_back(12'h0F0);
        tick_gap();
        chk("cut_pri", pri_color, 12'h0F0);
        chk("cut_done", done, 1'b1);
        chk("cut_busy_drop", busy, 1'b0);

        // Crossfade
        send(12'h00F, 2'b01);
        exp_done_q.push_back(12'h00F);
        for (int k = 0; k < 16; k++) begin
            tick_gap();
            chk($sformatf("xf_level_t%0d", k + 1), fade_level, xf_lvl[k]);
            chk($sformatf("xf_pri_t%0d", k + 1), pri_color, (k >= 7) ? 12'h00F : 12'h0F0);
        end
        chk("xf_done", done, 1'b1);
        chk("xf_busy", busy, 1'b0);

        // Fade-in
        send(12'hF00, 2'b10);
        exp_done_q.push_back(12'hF00);
        for (int k = 0; k < 9; k++) begin
            tick_gap();
            chk($sformatf("fi_level_t%0d", k + 1), fade_level, fi_lvl[k]);
            chk($sformatf("fi_pri_t%0d", k + 1), pri_color, 12'hF00);
        end
        chk("fi_done", done, 1'b1);

        // Request held while busy, accepted on the done cycle
        send(12'h0F0, 2'b00);
        exp_done_q.push_back(12'h0F0);
        bus.req_valid = 1'b1;
        bus.req_color = 12'h123;
        bus.req_mode  = 2'b10;
        repeat (5) step();
        chk("hold_ready", bus.req_ready, 1'b0);
        chk("hold_busy", busy, 1'b1);
        chk("hold_pri", pri_color, 12'hF00);
        exp_done_q.push_back(12'h123);
        tick_gap();
        chk("hold_done", done, 1'b1);
        chk("hold_ready_rise", bus.req_ready, 1'b1);
        chk("hold_pri_cut", pri_color, 12'h0F0);
        step();
        bus.req_color = 12'hABC;
        bus.req_valid = 1'b0;
        chk("hold_accept_busy", busy, 1'b1);
        chk("hold_accept_ready", bus.req_ready, 1'b0);
        for (int k = 0; k < 9; k++) begin
            tick_gap();
            if (k == 0) begin
                chk("hold_fi_pri", pri_color, 12'h123);
                chk("hold_fi_level", fade_level, 4'd3);
            end
        end
        chk("hold_fi_end_level", fade_level, 4'd0);
        chk("hold_fi_done", done, 1'b1);

        // Tick coincident with accept, mode 11 as cut
        frame_tick = 1'b1;
        send(12'h555, 2'b11);
        frame_tick = 1'b0;
        chk("m11_busy", busy, 1'b1);
        chk("m11_pri_hold", pri_color, 12'h123);
        exp_done_q.push_back(12'h555);
        tick_gap();
        chk("m11_pri", pri_color, 12'h555);
        chk("m11_done", done, 1'b1);

        // Coincident tick not counted in a crossfade; multi-cycle tick counts per cycle
        frame_tick = 1'b1;
        send(12'h0AA, 2'b01);
        frame_tick = 1'b0;
        chk("co_level0", fade_level, 4'd0);
        tick_gap();
        chk("co_level_t1", fade_level, 4'd0);
        repeat (19) step();
        frame_tick = 1'b1;
        step();
        step();
        frame_tick = 1'b0;
        chk("wide_tick_level", fade_level, 4'd1);
        tick_gap();
        chk("pre_rst_level", fade_level, 4'd2);
        chk("pre_rst_busy", busy, 1'b1);

        // Asynchronous reset mid-fade
        #2 rst_n = 1'b0;
        #1 chk_idle_defaults("rst_mid");
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("post_rst_pri", pri_color, 12'hFFF);

        send(12'h321, 2'b00);
        exp_done_q.push_back(12'h321);
        tick_gap();
        chk("post_rst_cut_pri", pri_color, 12'h321);
        chk("post_rst_cut_done", done, 1'b1);

        repeat (3) step();
        chk("sb_empty", exp_done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
